// File: rtl/jesd_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jesd_tx_pkg
//  Description : Shared types, lane/sample constants and lane packing helper
//                for the JESD204B TX transport-layer sample packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package jesd_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int LANES  = 2;
    localparam int SLOT_W = 16;
    localparam int LANE_W = 32;

    // Octet-order one lane: the MSB octet of each slot is transmitted first,
    // and the earlier sample s0 precedes s1.
    function automatic logic [LANE_W-1:0] pack_lane(
        input logic [SLOT_W-1:0] s0,
        input logic [SLOT_W-1:0] s1
    );
        return {s1[7:0], s1[15:8], s0[7:0], s0[15:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/jesd_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : jesd_tx_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with synchronous
//                flush. Occupancy counter resolves full/empty; pointers wrap
//                modulo depth. A push while full is dropped even if a pop
//                happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module jesd_tx_sync_fifo #(
    parameter int DW = 64,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage array: written on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/jesd_tx_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : jesd_tx_sample_packer
//  Description : JESD204B TX transport stage for a 2-lane link. Buffers
//                sample words, packs them into octet-ordered lane words,
//                tracks link readiness and reports/counts underflow.
//                Optional test ramp enabled by macro JESD_TX_PACKER_RAMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module jesd_tx_sample_packer
    import jesd_tx_pkg::*;
#(
    parameter int N       = 14,
    parameter int FIFO_AW = 2,
    parameter int CNT_W   = 16
) (
    input  logic             txlink_clk,
    input  logic             txlink_rst,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    input  logic             frame_ready,
    input  logic             link_ready,
`ifdef JESD_TX_PACKER_RAMP_EN
    input  logic             ramp_en,
`endif
    output logic             link_valid,
    output logic [63:0]      link_data,
    output logic             frame_error,
    output logic [CNT_W-1:0] underflow_cnt,
    output logic [1:0]       state
);

    // Keeps the N-bit left-justified sample, zeroes the tail bits of a slot.
    localparam logic [SLOT_W-1:0] c_SLOT_MASK =
        ~((SLOT_W'(1) << (SLOT_W - N)) - SLOT_W'(1));

    state_t           r_state;
    logic             r_link_valid;
    logic [63:0]      r_link_data;
    logic             r_frame_error;
    logic [CNT_W-1:0] r_underflow_cnt;

    logic        w_full;
    logic        w_empty;
    logic [63:0] w_head;
    logic [63:0] w_packed;
    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic        w_run_load;

    assign s_ready    = (r_state != IDLE) && !w_full;
    assign w_push     = s_valid && s_ready;
    assign w_flush    = !enable || ((r_state == RUN) && !frame_ready);
    assign w_run_load = (r_state == RUN) && enable && frame_ready && link_ready;
    assign w_pop      = w_run_load && !w_empty;

    jesd_tx_sync_fifo #(
        .DW (64),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (txlink_clk),
        .rst     (txlink_rst),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_packed[g*LANE_W +: LANE_W] = pack_lane(
            w_head[g*LANE_W          +: SLOT_W] & c_SLOT_MASK,
            w_head[g*LANE_W + SLOT_W +: SLOT_W] & c_SLOT_MASK);
    end

`ifdef JESD_TX_PACKER_RAMP_EN
    logic [N-1:0]  r_ramp;
    logic [N-1:0]  w_ramp_next;
    logic [63:0]   w_ramp_word;

    assign w_ramp_next = r_ramp + N'(1);
    assign w_ramp_word = {LANES{pack_lane(SLOT_W'(r_ramp)      << (SLOT_W - N),
                                          SLOT_W'(w_ramp_next) << (SLOT_W - N))}};

    // Ramp value advances by two samples per consumed ramp word; it restarts
    // from zero whenever the block is not streaming in RUN.
    always_ff @(posedge txlink_clk) begin
        if (txlink_rst || (r_state != RUN) || !enable || !frame_ready) begin
            r_ramp <= '0;
        end else if (ramp_en && link_ready) begin
            r_ramp <= r_ramp + N'(2);
        end
    end
`endif

    // Control FSM with registered link outputs and underflow accounting.
    always_ff @(posedge txlink_clk) begin
        if (txlink_rst) begin
            r_state         <= IDLE;
            r_link_valid    <= 1'b0;
            r_link_data     <= '0;
            r_frame_error   <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            r_frame_error <= 1'b0;
            if (!enable) begin
                r_state      <= IDLE;
                r_link_valid <= 1'b0;
                r_link_data  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state      <= ARM;
                        r_link_valid <= 1'b0;
                    end
                    ARM: begin
                        if (frame_ready && !w_empty) begin
                            r_state      <= RUN;
                            r_link_valid <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!frame_ready) begin
                            r_state      <= ARM;
                            r_link_valid <= 1'b0;
                            r_link_data  <= '0;
                        end else begin
                            r_link_valid <= 1'b1;
                            if (link_ready) begin
`ifdef JESD_TX_PACKER_RAMP_EN
                                if (ramp_en) begin
                                    r_link_data <= w_ramp_word;
                                end else
`endif
                                if (!w_empty) begin
                                    r_link_data <= w_packed;
                                end else begin
                                    r_link_data   <= '0;
                                    r_frame_error <= 1'b1;
                                    if (r_underflow_cnt != {CNT_W{1'b1}}) begin
                                        r_underflow_cnt <= r_underflow_cnt + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign link_valid    = r_link_valid;
    assign link_data     = r_link_data;
    assign frame_error   = r_frame_error;
    assign underflow_cnt = r_underflow_cnt;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jesd_tx_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jesd_tx_sample_packer
//  Description : Scoreboard bench for jesd_tx_sample_packer. A transaction
//                level model predicts the registered outputs after every
//                clock edge; a monitor compares them half a cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jesd_tx_sample_packer;

    localparam int N     = 14;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic        frame_ready = 1'b0;
    logic        link_ready = 1'b0;
`ifdef JESD_TX_PACKER_RAMP_EN
    logic        ramp_en = 1'b0;
`endif
    logic        link_valid;
    logic [63:0] link_data;
    logic        frame_error;
    logic [15:0] underflow_cnt;
    logic [1:0]  state;

    always #5 clk = ~clk;

    jesd_tx_sample_packer #(
        .N       (N),
        .FIFO_AW (2),
        .CNT_W   (16)
    ) dut (
        .txlink_clk    (clk),
        .txlink_rst    (rst),
        .enable        (enable),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .frame_ready   (frame_ready),
        .link_ready    (link_ready),
`ifdef JESD_TX_PACKER_RAMP_EN
        .ramp_en       (ramp_en),
`endif
        .link_valid    (link_valid),
        .link_data     (link_data),
        .frame_error   (frame_error),
        .underflow_cnt (underflow_cnt),
        .state         (state)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic        lv;
        logic [63:0] ld;
        logic        fe;
        logic [15:0] cnt;
        logic [1:0]  st;
        logic        sr;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_fifo[$];
    int          m_state = 0;   // 0 idle, 1 arming, 2 streaming
    logic        m_lv = 1'b0;
    logic [63:0] m_ld = '0;
    logic        m_fe = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        m_sr = 1'b0;
    int          m_ramp = 0;

    int checks = 0;
    int errors = 0;

    // Lane word from two slot values: transmitted octets are
    // s0 high, s0 low, s1 high, s1 low, first octet in the low byte.
    function automatic longint unsigned lane_of(longint unsigned s0, longint unsigned s1);
        return (s0 / 256) + (s0 % 256) * 256 + (s1 / 256) * 65536 + (s1 % 256) * 16777216;
    endfunction

    function automatic logic [63:0] pack_model(logic [63:0] d);
        longint unsigned res = 0;
        longint unsigned tail = 1 << (16 - N);
        for (int c = 0; c < 2; c++) begin
            longint unsigned s0 = (d >> (32 * c)) & 64'hFFFF;
            longint unsigned s1 = (d >> (32 * c + 16)) & 64'hFFFF;
            s0 = (s0 / tail) * tail;
            s1 = (s1 / tail) * tail;
            res = res | (lane_of(s0, s1) << (32 * c));
        end
        return res;
    endfunction

    function automatic logic [63:0] ramp_model(int r);
        longint unsigned s0 = longint'(r) * (1 << (16 - N));
        longint unsigned s1 = longint'((r + 1) % (1 << N)) * (1 << (16 - N));
        longint unsigned l  = lane_of(s0, s1);
        return (l << 32) | l;
    endfunction

    // Predict the state after each clock edge from the inputs that were
    // stable across it.
    always @(posedge clk) begin
        bit   push;
        bit   ramp_on;
        exp_t e;
`ifdef JESD_TX_PACKER_RAMP_EN
        ramp_on = ramp_en;
`else
        ramp_on = 1'b0;
`endif
        push = s_valid && m_sr;
        m_fe = 1'b0;
        if (rst) begin
            m_fifo.delete();
            m_state = 0; m_lv = 0; m_ld = '0; m_cnt = '0; m_ramp = 0;
        end else if (!enable) begin
            m_fifo.delete();
            m_state = 0; m_lv = 0; m_ld = '0; m_ramp = 0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (frame_ready && m_fifo.size() > 0) begin
                        m_state = 2;
                        m_lv = 1;
                    end
                    if (push) m_fifo.push_back(s_data);
                end
                default: begin
                    if (!frame_ready) begin
                        m_fifo.delete();
                        m_state = 1; m_lv = 0; m_ld = '0; m_ramp = 0;
                    end else begin
                        if (link_ready) begin
                            if (ramp_on) begin
                                if (m_fifo.size() > 0) void'(m_fifo.pop_front());
                                m_ld = ramp_model(m_ramp);
                                m_ramp = (m_ramp + 2) % (1 << N);
                            end else if (m_fifo.size() > 0) begin
                                m_ld = pack_model(m_fifo.pop_front());
                            end else begin
                                m_ld = '0;
                                m_fe = 1;
                                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                            end
                        end
                        if (push) m_fifo.push_back(s_data);
                    end
                end
            endcase
        end
        m_sr = (m_state != 0) && (m_fifo.size() < DEPTH);
        e.lv = m_lv; e.ld = m_ld; e.fe = m_fe; e.cnt = m_cnt;
        e.st = 2'(m_state); e.sr = m_sr;
        exp_q.push_back(e);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    // Monitor: compare the outputs half a cycle after each edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("link_valid",    64'(link_valid),    64'(e.lv));
            chk("link_data",     link_data,          e.ld);
            chk("frame_error",   64'(frame_error),   64'(e.fe));
            chk("underflow_cnt", 64'(underflow_cnt), 64'(e.cnt));
            chk("state",         64'(state),         64'(e.st));
            chk("s_ready",       64'(s_ready),       64'(e.sr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(bit r, bit en, bit sv, bit fr, bit lr, bit re, logic [63:0] d);
        @(negedge clk);
        rst = r; enable = en; s_valid = sv; frame_ready = fr; link_ready = lr;
        s_data = d;
`ifdef JESD_TX_PACKER_RAMP_EN
        ramp_en = re;
`else
        if (re) s_data = d;
`endif
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        repeat (2) step(1, 0, 0, 0, 0, 0, rnd64());
        // single word through an empty pipeline, then underflow
        step(0, 1, 0, 1, 1, 0, rnd64());
        step(0, 1, 1, 1, 1, 0, 64'h1234_5678_9ABC_DEF0);
        repeat (6) step(0, 1, 0, 1, 1, 0, rnd64());
        // backpressure: six offered, four accepted, released in order
        repeat (6) step(0, 1, 1, 1, 0, 0, rnd64());
        repeat (6) step(0, 1, 0, 1, 1, 0, rnd64());
        // two words then starvation
        repeat (2) step(0, 1, 1, 1, 1, 0, rnd64());
        repeat (5) step(0, 1, 0, 1, 1, 0, rnd64());
        // link resync with three words buffered
        repeat (3) step(0, 1, 1, 1, 0, 0, rnd64());
        step(0, 1, 0, 0, 1, 0, rnd64());
        repeat (3) step(0, 1, 0, 1, 1, 0, rnd64());
        step(0, 1, 1, 1, 1, 0, rnd64());
        repeat (3) step(0, 1, 0, 1, 1, 0, rnd64());
        // enable drop with frame_ready drop, then reset mid-run
        step(0, 0, 1, 0, 1, 0, rnd64());
        step(0, 1, 1, 1, 1, 0, rnd64());
        repeat (4) step(0, 1, 0, 1, 1, 0, rnd64());
        step(1, 1, 1, 1, 1, 0, rnd64());
        step(0, 1, 1, 1, 1, 0, rnd64());
        repeat (3) step(0, 1, 1, 1, 1, 0, rnd64());
        // ramp window of four consumed words
        repeat (4) step(0, 1, 1, 1, 1, 1, rnd64());
        repeat (2) step(0, 1, 0, 1, 1, 0, rnd64());
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 59) != 0,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) != 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 4) == 0,
                 rnd64());
        end
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL drain: got %0d pending expected at most 1", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
